icache_line_adapter: RTL and testbench
======================================

Name: icache_line_adapter

Overview:
- Sits between the instruction cache's read-only memory port (dfp_*) and the burst memory controller (bmem_*).
- Turns each 256-bit line read into one 4-beat × 64-bit burst and assembles the beats into a line.
- Returns the assembled line with a one-cycle dfp_resp.
- Optionally prefetches the next sequential line into a one-entry line buffer, so a sequential fetch miss is served without a memory round trip.

Parameters:
- PREFETCH_EN, 1, enables next-line prefetch into the line buffer (0 = pure demand adapter).
- BEATS, 4, beats per line; fixed at 4 (256/64). Elaboration error if changed.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock domain, asynchronous assert, active-low (rst=0 resets).
- dfp_addr  input  32  line address from the cache; bits [4:0] ignored.
- dfp_read  input  1  read request; the cache holds it high until dfp_resp.
- dfp_rdata  output  256  assembled line; beat k occupies [64k+63:64k].
- dfp_resp  output  1  one-cycle pulse; dfp_rdata valid for the latched request address.
- bmem_addr  output  32  burst address, line aligned.
- bmem_read  output  1  burst read request.
- bmem_write  output  1  tied 0.
- bmem_wdata  output  64  tied 0.
- bmem_ready  input  1  controller accepts bmem_read this cycle.
- bmem_raddr  input  32  address tag of the returning beat.
- bmem_rdata  input  64  beat data.
- bmem_rvalid  input  1  beat valid.

Behaviour:
- **Reset (rst=0, async):**
  - State IDLE; all outputs 0.
  - Buffer invalid; beat counter 0; partial line discarded.
  - A reset mid-burst drops the burst; beats still arriving after reset release are ignored by the raddr check (nothing outstanding).
- **States:** IDLE, D_ISSUE, D_COLLECT, RESP, PF_ISSUE, PF_COLLECT.
- **IDLE:**
  - dfp_read is sampled only in IDLE; latch req_line = dfp_addr[31:5].
  - Buffer hit (buf_valid && buf_line == dfp_addr[31:5]): load dfp_rdata from the buffer and go to RESP. dfp_resp rises the next cycle (1-cycle latency).
  - Otherwise go to D_ISSUE.
- **D_ISSUE / PF_ISSUE:**
  - Drive bmem_read=1 and bmem_addr={line,5'b0} combinationally.
  - Advance to the matching COLLECT state on the cycle bmem_ready=1.
- **COLLECT states:**
  - Accept a beat only when bmem_rvalid && bmem_raddr[31:5] == the in-flight line; otherwise drop it.
  - Beat counter (2-bit) wraps 3→0.
  - Burst completes on the 4th accepted beat.
- **D_COLLECT completion:**
  - The line is written into dfp_rdata; go to RESP.
  - dfp_resp is asserted the cycle after the last beat.
  - Minimum demand latency = 1 (IDLE) + issue wait + beat time + 1.
- **RESP:**
  - dfp_resp=1 for exactly one cycle; dfp_read is ignored in this cycle (the cache still holds it high).
  - dfp_rdata holds its value until the next RESP.
  - If PREFETCH_EN and buf_line ≠ req_line+1 (mod 2^27 wrap), go to PF_ISSUE with pf_line=req_line+1 and clear buf_valid.
  - Otherwise go to IDLE.
- **PF_COLLECT completion:** buffer ← line, buf_line ← pf_line, buf_valid=1, go to IDLE.
- **Demand arriving during prefetch:**
  - Bursts are never cancelled. The adapter does not sample dfp_read until it returns to IDLE.
  - The demand is then checked against the freshly filled buffer.
  - Required worst-case latency: prefetch completion + demand burst.
- **Stale requests:**
  - If the cache changes dfp_addr while a demand is in flight (after a flush), the adapter still returns the latched line.
  - The cache discards the mismatch and keeps dfp_read high; IDLE then picks up the new address.
- **Outstanding bursts:** at most one at any time. bmem_write and bmem_wdata are always 0.

Decomposition:
- types package:
  - CACHELINE_W=256, BEAT_W=64, LINE_OFFSET_W=5.
  - Enum line_adapter_state_t (the 6 states above).
- Sub-module bmem_beat_collector:
  - Inputs: clr, expect_line, bmem_rvalid/raddr/rdata.
  - Outputs: line[255:0], done (1-cycle pulse on the 4th beat).
  - Used for both demand and prefetch bursts.

Test Plan:
- Demand miss:
  - Stimulus: dfp_read, dfp_addr=0x0000_1024; bmem_ready on the 2nd D_ISSUE cycle; beats 0x11..,0x22..,0x33..,0x44.. back to back.
  - Required: bmem_addr=0x0000_1020; dfp_resp 1 cycle after beat 4; dfp_rdata[63:0]=0x11.., [255:192]=0x44...
- Prefetch then hit (PREFETCH_EN=1):
  - Stimulus: after the 0x1020 response, observe PF burst to 0x1040; complete it; then request 0x1044.
  - Required: dfp_resp 1 cycle after the request; no bmem_read; next prefetch goes to 0x1060.
- Stray beat:
  - Stimulus: during D_COLLECT for 0x2000, a beat arrives with raddr=0x3000.
  - Required: beat ignored; line still completes after 4 matching beats.
- Demand during prefetch:
  - Stimulus: dfp_read 0x5000 while the PF burst for 0x1060 has 2 beats left.
  - Required: no new bmem_read until the PF finishes; then bmem_addr=0x5000.
- Async reset mid-burst:
  - Stimulus: rst=0 after beat 2 (no clock edge); release rst.
  - Required: outputs 0 immediately; late beats are ignored; buf_valid=0; a following request 0x1020 misses.
- Wrap:
  - Stimulus: demand 0xFFFF_FFE0.
  - Required: prefetch bmem_addr=0x0000_0000.

Source files
------------

// File: rtl/icache_line_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_adapter_pkg
// Description : Shared widths, state encoding and address helper for the
//               instruction-cache line adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_line_adapter_pkg;

   localparam int unsigned CACHELINE_W   = 256;
   localparam int unsigned BEAT_W        = 64;
   localparam int unsigned LINE_OFFSET_W = 5;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned LINE_W        = ADDR_W - LINE_OFFSET_W;
   localparam int unsigned BEAT_CNT_W    = 2;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_D_ISSUE    = 3'd1,
      S_D_COLLECT  = 3'd2,
      S_RESP       = 3'd3,
      S_PF_ISSUE   = 3'd4,
      S_PF_COLLECT = 3'd5
   } line_adapter_state_t;

   // Line number back to a line-aligned byte address.
   function automatic logic [ADDR_W-1:0] line_to_addr(input logic [LINE_W-1:0] line);
      return {line, {LINE_OFFSET_W{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_adapter_collector.sv
`default_nettype none
// ============================================================================
// Module      : bmem_beat_collector
// Description : Assembles four 64-bit beats tagged with the expected line
//               into one 256-bit line; pulses done_o on the fourth beat with
//               that beat already merged into line_o.
// Revision    : 1.0 - initial release
// ============================================================================
module bmem_beat_collector
   import icache_line_adapter_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic [LINE_W-1:0]      expect_line_i,
   input  logic                   bmem_rvalid_i,
   input  logic [ADDR_W-1:0]      bmem_raddr_i,
   input  logic [BEAT_W-1:0]      bmem_rdata_i,
   output logic [CACHELINE_W-1:0] line_o,
   output logic                   done_o
);

   logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d;
   logic [CACHELINE_W-1:0] line_q, line_d;
   logic                   w_accept;
   logic                   w_unused_offset;

   // Beat offset bits only tag the beat position inside a line; they are not used.
   assign w_unused_offset = ^bmem_raddr_i[LINE_OFFSET_W-1:0];

   // Accept only beats belonging to the line in flight; merge at the beat slot.
   always_comb begin
      cnt_d    = cnt_q;
      line_d   = line_q;
      w_accept = bmem_rvalid_i && (bmem_raddr_i[ADDR_W-1:LINE_OFFSET_W] == expect_line_i);
      if (clr_i) begin
         cnt_d = '0;
      end else if (w_accept) begin
         cnt_d = cnt_q + 2'd1;
         line_d[{cnt_q, 6'd0} +: BEAT_W] = bmem_rdata_i;
      end
   end

   // The merged view lets the parent capture the full line on the last beat's edge.
   assign line_o = line_d;
   assign done_o = w_accept && !clr_i && (cnt_q == 2'd3);

   // Beat counter and partial line storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/icache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_adapter
// Description : Converts 256-bit I-cache line reads into 4x64-bit bursts,
//               returns the assembled line with a one-cycle dfp_resp and
//               optionally prefetches the next sequential line into a
//               one-entry line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_line_adapter
   import icache_line_adapter_pkg::*;
#(
   parameter bit          PREFETCH_EN = 1'b1,
   parameter int unsigned BEATS       = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      dfp_addr,
   input  logic                   dfp_read,
   output logic [CACHELINE_W-1:0] dfp_rdata,
   output logic                   dfp_resp,
   output logic [ADDR_W-1:0]      bmem_addr,
   output logic                   bmem_read,
   output logic                   bmem_write,
   output logic [BEAT_W-1:0]      bmem_wdata,
   input  logic                   bmem_ready,
   input  logic [ADDR_W-1:0]      bmem_raddr,
   input  logic [BEAT_W-1:0]      bmem_rdata,
   input  logic                   bmem_rvalid
);

   generate
      if (BEATS != 4) begin : g_beats_check
         $error("icache_line_adapter: BEATS must be 4 (256-bit line / 64-bit beat)");
      end
   endgenerate

   line_adapter_state_t    state_q, state_d;
   logic [LINE_W-1:0]      req_line_q, req_line_d;
   logic [LINE_W-1:0]      pf_line_q, pf_line_d;
   logic                   buf_valid_q, buf_valid_d;
   logic [LINE_W-1:0]      buf_line_q, buf_line_d;
   logic [CACHELINE_W-1:0] buf_data_q, buf_data_d;
   logic [CACHELINE_W-1:0] rdata_q, rdata_d;

   logic                   w_clr;
   logic [LINE_W-1:0]      w_expect_line;
   logic [CACHELINE_W-1:0] w_coll_line;
   logic                   w_coll_done;
   logic [LINE_W-1:0]      w_next_line;
   logic [LINE_W-1:0]      w_dfp_line;
   logic                   w_unused_offset;

   assign w_dfp_line      = dfp_addr[ADDR_W-1:LINE_OFFSET_W];
   assign w_unused_offset = ^dfp_addr[LINE_OFFSET_W-1:0];
   assign w_next_line     = req_line_q + {{(LINE_W-1){1'b0}}, 1'b1};

   assign dfp_rdata  = rdata_q;
   assign bmem_write = 1'b0;
   assign bmem_wdata = '0;

   bmem_beat_collector u_collector (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (w_clr),
      .expect_line_i (w_expect_line),
      .bmem_rvalid_i (bmem_rvalid),
      .bmem_raddr_i  (bmem_raddr),
      .bmem_rdata_i  (bmem_rdata),
      .line_o        (w_coll_line),
      .done_o        (w_coll_done)
   );

   // Next-state, datapath updates and Moore-style outputs.
   always_comb begin
      state_d       = state_q;
      req_line_d    = req_line_q;
      pf_line_d     = pf_line_q;
      buf_valid_d   = buf_valid_q;
      buf_line_d    = buf_line_q;
      buf_data_d    = buf_data_q;
      rdata_d       = rdata_q;
      dfp_resp      = 1'b0;
      bmem_read     = 1'b0;
      bmem_addr     = '0;
      w_clr         = 1'b1;
      w_expect_line = req_line_q;

      unique case (state_q)
         S_IDLE: begin
            if (dfp_read) begin
               req_line_d = w_dfp_line;
               if (buf_valid_q && (buf_line_q == w_dfp_line)) begin
                  rdata_d = buf_data_q;
                  state_d = S_RESP;
               end else begin
                  state_d = S_D_ISSUE;
               end
            end
         end
         S_D_ISSUE: begin
            bmem_read = 1'b1;
            bmem_addr = line_to_addr(req_line_q);
            if (bmem_ready) state_d = S_D_COLLECT;
         end
         S_D_COLLECT: begin
            w_clr         = 1'b0;
            w_expect_line = req_line_q;
            if (w_coll_done) begin
               rdata_d = w_coll_line;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            dfp_resp = 1'b1;
            // Skip the prefetch only when the buffer already holds the next line.
            if (PREFETCH_EN && !(buf_valid_q && (buf_line_q == w_next_line))) begin
               pf_line_d   = w_next_line;
               buf_valid_d = 1'b0;
               state_d     = S_PF_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PF_ISSUE: begin
            bmem_read = 1'b1;
            bmem_addr = line_to_addr(pf_line_q);
            if (bmem_ready) state_d = S_PF_COLLECT;
         end
         S_PF_COLLECT: begin
            w_clr         = 1'b0;
            w_expect_line = pf_line_q;
            if (w_coll_done) begin
               buf_data_d  = w_coll_line;
               buf_line_d  = pf_line_q;
               buf_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any burst in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         req_line_q  <= '0;
         pf_line_q   <= '0;
         buf_valid_q <= 1'b0;
         buf_line_q  <= '0;
         buf_data_q  <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_line_q  <= req_line_d;
         pf_line_q   <= pf_line_d;
         buf_valid_q <= buf_valid_d;
         buf_line_q  <= buf_line_d;
         buf_data_q  <= buf_data_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_line_adapter
// Description : Self-checking bench: burst memory responder, transaction
//               level model of the line buffer / prefetch rules, directed
//               scenarios followed by randomized request streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_line_adapter;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   dfp_addr;
   logic          dfp_read;
   logic [255:0]  dfp_rdata;
   logic          dfp_resp;
   logic [31:0]   bmem_addr;
   logic          bmem_read;
   logic          bmem_write;
   logic [63:0]   bmem_wdata;
   logic          bmem_ready;
   logic [31:0]   bmem_raddr;
   logic [63:0]   bmem_rdata;
   logic          bmem_rvalid;

   icache_line_adapter #(.PREFETCH_EN(1'b1), .BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
      .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (transaction level).
   logic [26:0]  exp_q[$];
   bit           m_buf_valid  = 0;
   logic [26:0]  m_buf_line   = '0;
   bit           m_pf_pending = 0;
   logic [26:0]  m_pf_line    = '0;
   logic [255:0] exp_hold     = '0;
   bit           expect_resp  = 0;

   // Memory responder state.
   bit           busy = 0;
   bit           real_beat = 0;
   bit           rand_mode = 0;
   bit           stray_once = 0;
   int           beats_acc = 0;
   int           beats_sent = 0;
   int           rd_cnt = 0;
   int           hs_count = 0;
   int           done_cyc = 0;
   logic [26:0]  cur_line = '0;
   logic [31:0]  last_hs_addr = '0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input logic [26:0] line, input int k);
      return {line, 5'b0, 32'(k)} ^ (64'h1111_1111_1111_1111 * 64'(k + 1));
   endfunction

   function automatic logic [255:0] line_data(input logic [26:0] line);
      logic [255:0] v;
      for (int k = 0; k < 4; k++) v[64*k +: 64] = beat_data(line, k);
      return v;
   endfunction

   // Memory controller model: accepts bursts, returns 4 tagged beats, checks issue order.
   initial begin
      bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst && bmem_read) begin
            if (busy) check("bmem_read_while_busy", 256'(bmem_read), 256'(0));
            else if (exp_q.size() == 0) check("unexpected_bmem_read", 256'(bmem_read), 256'(0));
            else check("bmem_addr", 256'(bmem_addr), 256'({exp_q[0], 5'b0}));
         end
         if (bmem_rvalid && real_beat) begin
            beats_acc++;
            if (beats_acc == 4) begin busy = 0; done_cyc = cyc; end
         end
         if (rst && bmem_read && bmem_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            busy = 1; cur_line = bmem_addr[31:5]; beats_acc = 0; beats_sent = 0;
            hs_count++; last_hs_addr = bmem_addr; rd_cnt = 0;
         end else if (rst && bmem_read) begin
            rd_cnt++;
         end
         @(posedge clk); #1;
         bmem_rvalid = 0; real_beat = 0;
         if (busy && beats_sent < 4) begin
            if (stray_once && beats_sent == 1) begin
               bmem_rvalid = 1; bmem_raddr = 32'h0000_3000; bmem_rdata = '1; stray_once = 0;
            end else if (rand_mode && $urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 1) begin
                  bmem_rvalid = 1; bmem_raddr = {cur_line + 27'd1, 5'd0}; bmem_rdata = 64'($urandom);
               end
            end else begin
               bmem_rvalid = 1; bmem_raddr = {cur_line, 5'(beats_sent * 8)};
               bmem_rdata = beat_data(cur_line, beats_sent); real_beat = 1; beats_sent++;
            end
         end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            bmem_rvalid = 1; bmem_raddr = $urandom; bmem_rdata = 64'($urandom);
         end
         bmem_ready = rand_mode ? (rd_cnt >= 3 || $urandom_range(0, 2) == 0) : (rd_cnt >= 1);
      end
   end

   // Every-cycle output checks: tied-off write port, held read data, no stray responses.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("bmem_write_tied", 256'(bmem_write), 256'(0));
            check("bmem_wdata_tied", 256'(bmem_wdata), 256'(0));
            if (!dfp_resp) check("dfp_rdata_hold", dfp_rdata, exp_hold);
            else if (!expect_resp) check("unexpected_dfp_resp", 256'(dfp_resp), 256'(0));
         end
      end
   end

   task automatic wait_quiet();
      int i = 0;
      while ((exp_q.size() != 0 || busy) && i < 1000) begin @(negedge clk); i++; end
      if (i >= 1000) begin
         n_checks++; n_fail++;
         $display("FAIL quiet_timeout: queue %0d busy %0d, required empty queue and idle memory", exp_q.size(), busy);
      end
      @(negedge clk);
   endtask

   task automatic do_request(input logic [31:0] addr, input bit chk_lat);
      logic [26:0] line;
      bit hit, got;
      int c0;
      line = addr[31:5];
      if (m_pf_pending) begin m_buf_valid = 1; m_buf_line = m_pf_line; m_pf_pending = 0; end
      hit = m_buf_valid && (m_buf_line == line);
      if (!hit) exp_q.push_back(line);
      @(posedge clk); #1;
      dfp_addr = addr; dfp_read = 1; expect_resp = 1;
      got = 0; c0 = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (i == 0) c0 = cyc;
         if (dfp_resp) got = 1;
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout: addr %h got no dfp_resp, required one", addr);
      end else begin
         check("dfp_rdata", dfp_rdata, line_data(line));
         if (hit && chk_lat) check("hit_latency", 256'(cyc), 256'(c0 + 1));
         if (!hit) check("miss_latency", 256'(cyc), 256'(done_cyc + 1));
         exp_hold = line_data(line);
         if (!(m_buf_valid && m_buf_line == line + 27'd1)) begin
            exp_q.push_back(line + 27'd1);
            m_buf_valid = 0; m_pf_pending = 1; m_pf_line = line + 27'd1;
         end
      end
      @(posedge clk); #1;
      dfp_read = 0; expect_resp = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hc, i;
      logic [31:0] prev, a;
      rst = 0; dfp_addr = '0; dfp_read = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dfp_resp", 256'(dfp_resp), 256'(0));
      check("reset_bmem_read", 256'(bmem_read), 256'(0));
      check("reset_bmem_addr", 256'(bmem_addr), 256'(0));
      check("reset_dfp_rdata", dfp_rdata, 256'(0));
      @(negedge clk); rst = 1;

      // Demand miss to 0x1024.
      do_request(32'h0000_1024, 0);
      check("miss_bmem_addr", 256'(last_hs_addr), 256'(32'h0000_1020));
      check("miss_beat0", 256'(dfp_rdata[63:0]), 256'(64'h1111_0131_1111_1111));
      check("miss_beat3", 256'(dfp_rdata[255:192]), 256'(64'h4444_5464_4444_4447));

      // Prefetch of 0x1040 completes, then 0x1044 hits without memory traffic.
      wait_quiet();
      check("pf_bmem_addr", 256'(last_hs_addr), 256'(32'h0000_1040));
      hc = hs_count;
      do_request(32'h0000_1044, 1);
      check("hit_no_bmem_read", 256'(hs_count), 256'(hc));
      i = 0;
      while (hs_count == hc && i < 50) begin @(negedge clk); i++; end
      check("next_pf_addr", 256'(last_hs_addr), 256'(32'h0000_1060));

      // Demand 0x5000 while the 0x1060 prefetch still has two beats left.
      i = 0;
      while (!(busy && beats_acc >= 2) && i < 50) begin @(negedge clk); #1; i++; end
      do_request(32'h0000_5000, 0);
      check("demand_after_pf_addr", 256'(last_hs_addr), 256'(32'h0000_5000));

      // Stray beat for 0x3000 during the 0x2000 collect.
      wait_quiet();
      stray_once = 1;
      do_request(32'h0000_2000, 1);
      check("stray_consumed", 256'(stray_once), 256'(0));

      // Asynchronous reset after two beats of a demand burst.
      wait_quiet();
      exp_q.push_back(27'h0000_7000 >> 5);
      @(posedge clk); #1;
      dfp_addr = 32'h0000_7000; dfp_read = 1; expect_resp = 1;
      i = 0;
      while (!(busy && beats_acc >= 2) && i < 50) begin @(negedge clk); #1; i++; end
      @(posedge clk); #2;
      rst = 0;
      #1;
      check("async_rst_dfp_resp", 256'(dfp_resp), 256'(0));
      check("async_rst_bmem_read", 256'(bmem_read), 256'(0));
      check("async_rst_bmem_addr", 256'(bmem_addr), 256'(0));
      check("async_rst_dfp_rdata", dfp_rdata, 256'(0));
      dfp_read = 0; expect_resp = 0;
      exp_q.delete(); exp_hold = '0;
      m_buf_valid = 0; m_pf_pending = 0;
      @(negedge clk); rst = 1;
      wait_quiet();
      repeat (3) @(negedge clk);
      check("late_beats_ignored", dfp_rdata, 256'(0));
      hc = hs_count;
      do_request(32'h0000_1020, 0);
      check("post_reset_miss", 256'(hs_count), 256'(hc + 1));

      // Wrap of the next-line prefetch.
      wait_quiet();
      do_request(32'hFFFF_FFE0, 0);
      wait_quiet();
      check("wrap_pf_addr", 256'(last_hs_addr), 256'(32'h0000_0000));

      // Randomized request streams with random memory timing and stray beats.
      rand_mode = 1;
      prev = 32'h0000_8000;
      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(0, 3))
            0: a = prev + 32'd32;
            1: a = prev + 32'd32 + 32'($urandom_range(0, 31));
            2: a = prev;
            default: a = {22'h000002, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
         endcase
         if ($urandom_range(0, 1) == 1) begin
            wait_quiet();
            do_request(a, 1);
         end else begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            do_request(a, 0);
         end
         prev = a;
      end
      wait_quiet();
      check("exp_queue_drained", 256'(exp_q.size()), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
